load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_byte_lane.sv | 40 ++++
 rtl/load_store_unit.sv | 130 +++++++++++++
 tb/tb_load_store_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_HALF = 1'b1;

  // A halfword must sit on an even byte address.
  function automatic logic is_misaligned(input logic size, input logic lane);
    return (size == SIZE_HALF) && lane;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane datapath: little-endian lane extract with sign/zero extension, and store merge.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  lane,
  input  logic                  size,
  input  logic                  zext,
  input  logic [7:0]            wbyte,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged
);

  logic [7:0] lane_byte_s;

  // Load path: select the addressed byte and extend it, halfwords pass through.
  always_comb begin
    lane_byte_s = lane ? word[15:8] : word[7:0];
    if (size == SIZE_HALF) begin
      load_data = word;
    end else if (zext) begin
      load_data = {{(DATA_WIDTH-8){1'b0}}, lane_byte_s};
    end else begin
      load_data = {{(DATA_WIDTH-8){lane_byte_s[7]}}, lane_byte_s};
    end
  end

  // Store path: replace only the addressed byte of the word read back.
  always_comb begin
    merged = word;
    if (lane) begin
      merged[15:8] = wbyte;
    end else begin
      merged[7:0] = wbyte;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word-wide memory,
// with byte stores done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH:0]   req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_WE,
  output logic [ADDR_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0] mem_WD,
  input  logic [DATA_WIDTH-1:0] mem_RD
);

  lsu_state_e            state_r, state_nxt_s;
  logic                  we_r, size_r, unsigned_r, err_r;
  logic [ADDR_WIDTH:0]   addr_r;
  logic [DATA_WIDTH-1:0] wdata_r, rd_word_r;
  logic [DATA_WIDTH-1:0] load_data_s, merged_s;

  lsu_byte_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .word      (rd_word_r),
    .lane      (addr_r[0]),
    .size      (size_r),
    .zext      (unsigned_r),
    .wbyte     (wdata_r[7:0]),
    .load_data (load_data_s),
    .merged    (merged_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!req_valid) begin
          state_nxt_s = ST_IDLE;
        end else if (is_misaligned(req_size, req_addr[0])) begin
          state_nxt_s = ST_RESP;
        end else if (req_we && (req_size == SIZE_HALF)) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_READ:  state_nxt_s = we_r ? ST_WRITE : ST_RESP;
      ST_WRITE: state_nxt_s = ST_RESP;
      ST_RESP:  state_nxt_s = rsp_ready ? ST_IDLE : ST_RESP;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Request capture on acceptance and read-data capture when leaving READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r       <= 1'b0;
      size_r     <= SIZE_BYTE;
      unsigned_r <= 1'b0;
      err_r      <= 1'b0;
      addr_r     <= {(ADDR_WIDTH+1){1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
      rd_word_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      if ((state_r == ST_IDLE) && req_valid) begin
        we_r       <= req_we;
        size_r     <= req_size;
        unsigned_r <= req_unsigned;
        err_r      <= is_misaligned(req_size, req_addr[0]);
        addr_r     <= req_addr;
        wdata_r    <= req_wdata;
      end
      if (state_r == ST_READ) begin
        rd_word_r <= mem_RD;
      end
    end
  end

  // Outputs decode from registered state only; rst_n gates the two that must fall with reset.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = {DATA_WIDTH{1'b0}};
    mem_WE    = 1'b0;
    mem_A     = {ADDR_WIDTH{1'b0}};
    mem_WD    = {DATA_WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: req_ready = rst_n;
      ST_READ: mem_A = addr_r[ADDR_WIDTH:1];
      ST_WRITE: begin
        mem_WE = rst_n;
        mem_A  = addr_r[ADDR_WIDTH:1];
        mem_WD = (size_r == SIZE_HALF) ? wdata_r : merged_s;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_r;
        if (!err_r && !we_r) begin
          rsp_rdata = load_data_s;
        end else begin
          rsp_rdata = {DATA_WIDTH{1'b0}};
        end
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit against a word-wide memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_size, req_unsigned;
  logic [8:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic        mem_WE;
  logic [7:0]  mem_A;
  logic [15:0] mem_WD, mem_RD;

  logic [15:0] mem [0:255];
  int          n_asserts = 0;
  int          n_fail = 0;
  int          we_cnt = 0;
  logic [7:0]  last_a = 8'h00;
  logic [15:0] last_wd = 16'h0000;

  load_store_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_WE === 1'b1) mem[mem_A] <= mem_WD;
  end
  assign mem_RD = mem[mem_A];

  always @(negedge clk) begin
    if (mem_WE === 1'b1) begin
      we_cnt  <= we_cnt + 1;
      last_a  <= mem_A;
      last_wd <= mem_WD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic we, input logic size, input logic uns,
                         input logic [8:0] addr, input logic [15:0] wdata, input int exp_lat,
                         input logic [15:0] exp_rdata, input logic exp_err, input int exp_wes,
                         input logic [7:0] exp_a, input logic [15:0] exp_wd, input int stall);
    int lat;
    int we0;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    we0 = we_cnt;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_wdata = 16'h0000;
    chk({tag, ".busy"}, 32'(req_ready), 32'd0);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    for (int k = 0; k < stall; k++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1; req_addr = 9'h004; req_wdata = 16'h5555;
      @(posedge clk); #1;
      chk({tag, ".stall_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".stall_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
      chk({tag, ".stall_err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ".stall_we"}, 32'(mem_WE), 32'd0);
    end
    req_valid = 1'b0; req_we = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".done_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".we_cnt"}, 32'(we_cnt - we0), 32'(exp_wes));
    if (exp_wes > 0) begin
      chk({tag, ".mem_A"}, 32'(last_a), 32'(exp_a));
      chk({tag, ".mem_WD"}, 32'(last_wd), 32'(exp_wd));
    end
  endtask

  initial begin
    int we0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0; req_unsigned = 1'b0;
    req_addr = 9'h000; req_wdata = 16'h0000; rsp_ready = 1'b0;
    #12;
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.outs", 32'({rsp_valid, rsp_err, mem_WE}), 32'd0);
    chk("rst.data", 32'({rsp_rdata, mem_WD}), 32'd0);
    chk("rst.addr", 32'(mem_A), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel.ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    run_req("sh",      1'b1, 1'b1, 1'b0, 9'h004, 16'hBEEF, 2, 16'h0000, 1'b0, 1, 8'd2, 16'hBEEF, 0);
    run_req("lh",      1'b0, 1'b1, 1'b0, 9'h004, 16'h0000, 2, 16'hBEEF, 1'b0, 0, 8'd0, 16'h0000, 0);
    run_req("sb",      1'b1, 1'b0, 1'b0, 9'h005, 16'hAB12, 3, 16'h0000, 1'b0, 1, 8'd2, 16'h12EF, 0);
    run_req("lb_s",    1'b0, 1'b0, 1'b0, 9'h004, 16'h0000, 2, 16'hFFEF, 1'b0, 0, 8'd0, 16'h0000, 0);
    run_req("lb_u",    1'b0, 1'b0, 1'b1, 9'h004, 16'h0000, 2, 16'h00EF, 1'b0, 0, 8'd0, 16'h0000, 0);
    run_req("lb_hi",   1'b0, 1'b0, 1'b0, 9'h005, 16'h0000, 2, 16'h0012, 1'b0, 0, 8'd0, 16'h0000, 0);
    run_req("lh_mis",  1'b0, 1'b1, 1'b0, 9'h003, 16'h0000, 1, 16'h0000, 1'b1, 0, 8'd0, 16'h0000, 0);
    run_req("sh_mis",  1'b1, 1'b1, 1'b0, 9'h007, 16'h7777, 1, 16'h0000, 1'b1, 0, 8'd0, 16'h0000, 0);
    run_req("lh_stall",1'b0, 1'b1, 1'b0, 9'h004, 16'h0000, 2, 16'h12EF, 1'b0, 0, 8'd0, 16'h0000, 3);

    // Reset arriving while a byte store is in its write cycle.
    we0 = we_cnt;
    chk("rw.ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 1'b0; req_unsigned = 1'b0;
    req_addr = 9'h004; req_wdata = 16'h0034;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    chk("rw.read_we", 32'(mem_WE), 32'd0);
    chk("rw.read_a", 32'(mem_A), 32'd2);
    @(posedge clk); #1;
    chk("rw.write_we", 32'(mem_WE), 32'd1);
    chk("rw.write_wd", 32'(mem_WD), 32'h1234);
    #1 rst_n = 1'b0;
    #1;
    chk("rw.rst_we", 32'(mem_WE), 32'd0);
    chk("rw.rst_addr", 32'(mem_A), 32'd0);
    chk("rw.rst_wd", 32'(mem_WD), 32'd0);
    chk("rw.rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
    chk("rw.rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rw.rel_ready", 32'(req_ready), 32'd1);
    chk("rw.rel_valid", 32'(rsp_valid), 32'd0);
    chk("rw.no_write", 32'(we_cnt - we0), 32'd0);
    @(posedge clk); #1;
    run_req("lh_after",1'b0, 1'b1, 1'b0, 9'h004, 16'h0000, 2, 16'h12EF, 1'b0, 0, 8'd0, 16'h0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
